gamma_pwm_decoder: RTL

//  Inverse of the gamma brightness path: observes an 8-bit-period PWM waveform, measures its duty (0..255)
//  and maps it back to the nearest 4-bit brightness level (0..15) of the team gamma table.

---
 rtl/gamma_pwm_decoder.sv | 88 ++++++++
 1 files changed

// File: rtl/gamma_pwm_decoder.sv
// gamma_pwm_decoder: measures PWM duty over back-to-back 256-cycle windows and decodes it to the nearest 4-bit gamma level
module gamma_pwm_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pwm_in,
  output logic [7:0] duty_out,
  output logic       duty_valid,
  output logic [3:0] level_out,
  output logic       level_valid,
  output logic       level_changed,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  // THR[k] is the lowest duty decoding to level k; midpoint ties round down
  localparam logic [7:0] THR [16] = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd9, 8'd14, 8'd21, 8'd31,
                                      8'd44, 8'd60, 8'd81, 8'd107, 8'd138, 8'd176, 8'd211, 8'd240};
  logic [SYNC_STAGES-1:0] sync_q;
  logic [PERIOD_W-1:0]    wcnt_q;
  logic [PERIOD_W:0]      hcnt_q, hcnt_d;
  logic [7:0]             duty_q;
  logic [3:0]             level_q, k_q, cand_q, cand_d;
  logic                   duty_valid_q, level_valid_q, level_changed_q;
  state_t                 state_q;
  always_comb begin
    hcnt_d = hcnt_q + (PERIOD_W+1)'(sync_q[SYNC_STAGES-1]);
    cand_d = (duty_q >= THR[k_q]) ? k_q : cand_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q          <= '0;
      wcnt_q          <= '0;
      hcnt_q          <= '0;
      duty_q          <= '0;
      level_q         <= '0;
      k_q             <= '0;
      cand_q          <= '0;
      duty_valid_q    <= 1'b0;
      level_valid_q   <= 1'b0;
      level_changed_q <= 1'b0;
      state_q         <= IDLE;
    end else begin
      sync_q          <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      duty_valid_q    <= 1'b0;
      level_valid_q   <= 1'b0;
      level_changed_q <= 1'b0;
      if (!en) begin
        wcnt_q  <= '0;
        hcnt_q  <= '0;
        state_q <= IDLE;
      end else begin
        wcnt_q <= wcnt_q + PERIOD_W'(1);
        hcnt_q <= (&wcnt_q) ? '0 : hcnt_d;
        if (&wcnt_q) begin
          duty_q       <= hcnt_d[PERIOD_W] ? 8'hff : hcnt_d[7:0];
          duty_valid_q <= 1'b1;
        end
        case (state_q)
          IDLE: if (duty_valid_q) begin
            state_q <= SEARCH;
            k_q     <= 4'd1;
            cand_q  <= 4'd0;
          end
          SEARCH: begin
            cand_q <= cand_d;
            k_q    <= k_q + 4'd1;
            if (k_q == 4'd15) begin
              state_q         <= DONE;
              level_q         <= cand_d;
              level_valid_q   <= 1'b1;
              level_changed_q <= cand_d != level_q;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign duty_out      = duty_q;
  assign duty_valid    = duty_valid_q;
  assign level_out     = level_q;
  assign level_valid   = level_valid_q;
  assign level_changed = level_changed_q;
  assign busy          = state_q == SEARCH;
endmodule
